pr_stage_skid: RTL and testbench

- Parametrised pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
- Replaces the fixed-field stage registers between pipeline stages, for example IF/ID and ID/EX.
- Carries an opaque payload plus a PC field and produces a registered incremented PC.
- Supports flush-to-bubble, back-pressure without combinational ready paths, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pr_stage_skid_if.sv | 26 ++
 rtl/pr_entry_reg.sv | 34 +++
 rtl/pr_stage_skid.sv | 110 +++++++++++
 tb/tb_pr_stage_skid.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: bubble encoding, default PC step and
// the canonical stage-entry layout used between IF/ID and ID/EX.
package pipe_pkg;

    localparam logic [5:0]  NOP_OPCODE   = 6'b111111;
    localparam logic [31:0] BUBBLE_INSTR = {NOP_OPCODE, 26'd0};
    localparam int unsigned PC_INC_DEF   = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] pc_inc;
    } stage_entry_t;

endpackage

// File: rtl/pr_stage_skid_if.sv
// Upstream/downstream valid-ready bundle of one pipeline stage.
// slave = the stage itself, master = the surrounding pipeline.
interface pr_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_pc_inc;

    modport slave (
        input  in_valid, in_data, in_pc, out_ready,
        output in_ready, out_valid, out_data, out_pc, out_pc_inc
    );

    modport master (
        output in_valid, in_data, in_pc, out_ready,
        input  in_ready, out_valid, out_data, out_pc, out_pc_inc
    );
endinterface

// File: rtl/pr_entry_reg.sv
// One held stage entry with its valid bit; clear wins over load, reset wins
// over both and parks the payload at RST_VAL.
module pr_entry_reg #(
    parameter int           W       = 96,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_q
);

    logic         r_valid;
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= RST_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;

endmodule

// File: rtl/pr_stage_skid.sv
// Pipeline-stage register with a two-entry skid (M presented, S overflow),
// flush-to-bubble and a saturating downstream stall counter.
module pr_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                PC_W   = 32,
    parameter int unsigned       PC_INC = PC_INC_DEF,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_INSTR),
    parameter int                CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pr_stage_skid_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_inc;
    } entry_t;

    localparam int     EW      = $bits(entry_t);
    localparam entry_t RST_ENT = '{data: BUBBLE, pc: '0, pc_inc: '0};

    entry_t           w_in_ent;
    entry_t           w_m_d;
    entry_t           w_m_ent;
    entry_t           w_s_ent;
    logic             w_m_valid;
    logic             w_s_valid;
    logic             w_m_load;
    logic             w_m_clear;
    logic             w_s_load;
    logic             w_s_clear;
    logic             w_acc;
    logic             w_drn;
    logic [CNT_W-1:0] r_stall_cnt;

    // pc_inc is fixed at capture time and travels with the entry
    assign w_in_ent = '{data:   bus.in_data,
                        pc:     bus.in_pc,
                        pc_inc: bus.in_pc + PC_W'(PC_INC)};

    assign w_acc = bus.in_valid & bus.in_ready;
    assign w_drn = w_m_valid & bus.out_ready;

    always_comb begin
        w_m_load  = 1'b0;
        w_m_clear = 1'b0;
        w_s_load  = 1'b0;
        w_s_clear = 1'b0;
        w_m_d     = w_in_ent;
        if (flush) begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
        end else if (!w_m_valid || w_drn) begin
            if (w_s_valid) begin
                w_m_load = 1'b1;
                w_m_d    = w_s_ent;
                if (w_acc) w_s_load  = 1'b1;
                else       w_s_clear = 1'b1;
            end else if (w_acc) begin
                w_m_load = 1'b1;
            end else begin
                w_m_clear = 1'b1;
            end
        end else if (w_acc) begin
            w_s_load = 1'b1;
        end
    end

    pr_entry_reg #(.W(EW), .RST_VAL(RST_ENT)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_d     (w_m_d),
        .o_valid (w_m_valid),
        .o_q     (w_m_ent)
    );

    pr_entry_reg #(.W(EW), .RST_VAL(RST_ENT)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_d     (w_in_ent),
        .o_valid (w_s_valid),
        .o_q     (w_s_ent)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_m_valid && !bus.out_ready && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    // ready depends only on S occupancy, never on out_ready
    assign bus.in_ready   = ~w_s_valid & ~rst;
    assign bus.out_valid  = w_m_valid;
    assign bus.out_data   = w_m_valid ? w_m_ent.data   : BUBBLE;
    assign bus.out_pc     = w_m_valid ? w_m_ent.pc     : '0;
    assign bus.out_pc_inc = w_m_valid ? w_m_ent.pc_inc : '0;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_pr_stage_skid.sv
// Randomised and directed bench for pr_stage_skid against a depth-2 FIFO model.
module tb_pr_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pr_stage_skid_if #(.DATA_W(DW), .PC_W(PW)) bus ();

    pr_stage_skid #(
        .DATA_W (DW),
        .PC_W   (PW),
        .PC_INC (4),
        .BUBBLE (32'hFC00_0000),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        src[$];
    ent_t        held[$];
    int unsigned exp_cnt;
    int          n_chk;
    int          n_err;
    bit          ofr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] pc);
        src.push_back('{d: d, pc: pc});
    endtask

    // Model: the stage is a 2-deep FIFO; an offer is taken when fewer than two
    // entries are held, the head leaves when out_ready is high.
    task automatic cycle();
        ent_t        e;
        bit          acc;
        bit          drn;
        logic [31:0] inc;
        bus.in_valid = ofr && (src.size() > 0);
        bus.in_data  = (src.size() > 0) ? src[0].d  : 32'h0;
        bus.in_pc    = (src.size() > 0) ? src[0].pc : 32'h0;
        @(posedge clk);
        acc = bus.in_valid && !rst && (held.size() < 2);
        drn = (held.size() > 0) && bus.out_ready;
        if (acc) e = src.pop_front();
        if (rst) begin
            held.delete();
            exp_cnt = 0;
        end else begin
            if (held.size() > 0 && !bus.out_ready && exp_cnt < CMAX) exp_cnt++;
            if (flush) held.delete();
            else begin
                if (drn) void'(held.pop_front());
                if (acc) held.push_back(e);
            end
        end
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(held.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(!rst && held.size() < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
        if (held.size() > 0) begin
            inc = held[0].pc + 32'd4;
            chk("out_data", 64'(bus.out_data), 64'(held[0].d));
            chk("out_pc", 64'(bus.out_pc), 64'(held[0].pc));
            chk("out_pc_inc", 64'(bus.out_pc_inc), 64'(inc));
        end else begin
            chk("bubble_data", 64'(bus.out_data), 64'h0000_0000_FC00_0000);
            chk("bubble_pc", 64'(bus.out_pc), 64'h0);
            chk("bubble_pc_inc", 64'(bus.out_pc_inc), 64'h0);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_cnt = 0;
        ofr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        // reset held for two cycles, then idle
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);

        // streaming under continuous out_ready
        bus.out_ready = 1'b1;
        ofr = 1'b1;
        push(32'hA, 32'h100);
        push(32'hB, 32'h104);
        push(32'hC, 32'h108);
        cycles(5);

        // back-pressure fills the skid, then release
        bus.out_ready = 1'b0;
        push(32'hA1, 32'h200);
        push(32'hB1, 32'h204);
        push(32'hC1, 32'h208);
        cycles(4);
        bus.out_ready = 1'b1;
        cycles(5);

        // flush with both entries held; upstream cancels its offer too
        bus.out_ready = 1'b0;
        push(32'hA2, 32'h300);
        push(32'hB2, 32'h304);
        cycles(3);
        push(32'hD2, 32'h308);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        src.delete();
        push(32'hE2, 32'h30C);
        bus.out_ready = 1'b1;
        cycles(3);

        // flush while an offer is accepted: the offer is dropped
        bus.out_ready = 1'b0;
        push(32'hA3, 32'h400);
        cycles(2);
        push(32'hD3, 32'h404);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        cycles(2);

        // PC wrap
        push(32'h77, 32'hFFFF_FFFC);
        push(32'h78, 32'hFFFF_FFF8);
        cycles(4);

        // stall counter saturation
        bus.out_ready = 1'b0;
        push(32'h99, 32'h500);
        cycles(20);
        bus.out_ready = 1'b1;
        cycles(2);

        // reset in the middle of a full stalled stage
        bus.out_ready = 1'b0;
        push(32'h1, 32'h600);
        push(32'h2, 32'h604);
        push(32'h3, 32'h608);
        cycles(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycles(2);
        bus.out_ready = 1'b1;
        cycles(3);

        // randomised traffic
        for (int i = 0; i < 500; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            ofr   = ($urandom_range(0, 3) != 0);
            if (src.size() < 3) push($urandom, $urandom);
            cycle();
        end
        rst = 1'b0;
        flush = 1'b0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
